// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// next_idx returns the first set request found scanning upward from ptr, wrapping mod N_REQ.
package rr_arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic logic [IDX_W-1:0] next_idx(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
      logic [N_REQ-1:0] rot;
      logic [IDX_W-1:0] idx;
      logic             found;
      // Doubling the vector turns the wrap-around scan into a plain shift.
      rot   = N_REQ'({req, req} >> ptr);
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && rot[i]) begin
            idx   = ptr + IDX_W'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/decoder_3to8_en.sv
// Enabled 3-to-8 one-hot decoder; all zeros when en is low.
module decoder_3to8_en
   import rr_arb_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [N_REQ-1:0] dec
);

   always_comb begin
      dec = '0;
      if (en) dec[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for one shared 8-way resource with a per-grant hold limit.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; pick next requester from ptr when req is nonzero
//   GRANT | gnt_idx owns the resource until done, req drop or hold limit
module rr_arbiter_8
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = $clog2(MAX_HOLD)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   arb_state_t       state;
   logic [IDX_W-1:0] ptr;
   logic [HOLD_W-1:0] hold_cnt;

   logic hold_tc;
   logic rel_normal;
   logic rel_any;

   // Hold timer counts down from MAX_HOLD-1; terminal count marks the last permitted cycle.
   assign hold_tc    = (hold_cnt == '0);
   assign rel_normal = done | ~req[gnt_idx];
   assign rel_any    = rel_normal | hold_tc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt_idx   <= next_idx(req, ptr);
                  gnt_valid <= 1'b1;
                  hold_cnt  <= HOLD_W'(MAX_HOLD - 1);
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (rel_any) begin
                  state     <= IDLE;
                  gnt_valid <= 1'b0;
                  ptr       <= gnt_idx + 3'd1;
                  timeout   <= ~rel_normal;
               end else if (!hold_tc) begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               gnt_valid <= 1'b0;
            end
         endcase
      end
   end

   decoder_3to8_en u_dec (
      .idx (gnt_idx),
      .en  (gnt_valid),
      .dec (gnt)
   );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 built with MAX_HOLD=4; expected values are hand-derived.
// Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
module tb_rr_arbiter_8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int n_cmp = 0;
   int n_err = 0;

   rr_arbiter_8 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                          input logic e_valid, input logic e_to);
      chk({tag, ".gnt"},       gnt,              e_gnt);
      chk({tag, ".gnt_idx"},   {5'd0, gnt_idx},  {5'd0, e_idx});
      chk({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, e_valid});
      chk({tag, ".timeout"},   {7'd0, timeout},  {7'd0, e_to});
   endtask

   task automatic chk_ptr(input string tag, input logic [2:0] e_ptr);
      chk({tag, ".ptr"}, {5'd0, dut.ptr}, {5'd0, e_ptr});
   endtask

   initial begin
      logic [7:0] e;
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      cyc();
      cyc();
      chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      chk_ptr("reset", 3'd0);
      rst = 1'b0;

      // Single requester, released by done in its third cycle
      req = 8'h04;
      cyc();
      chk_out("t1_grant", 8'h04, 3'd2, 1'b1, 1'b0);
      cyc();
      cyc();
      chk_out("t1_cyc3", 8'h04, 3'd2, 1'b1, 1'b0);
      done = 1'b1;
      cyc();
      done = 1'b0;
      chk_out("t1_release", 8'h00, 3'd2, 1'b0, 1'b0);
      chk_ptr("t1_release", 3'd3);
      cyc();
      chk_out("t1_regrant", 8'h04, 3'd2, 1'b1, 1'b0);
      req = 8'h00;
      cyc();
      chk_out("t1_reqdrop", 8'h00, 3'd2, 1'b0, 1'b0);
      chk_ptr("t1_reqdrop", 3'd3);

      // All requesting from ptr=0: grants walk 0..7 then wrap
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      req = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         e = 8'h01 << (k % 8);
         cyc();
         chk_out($sformatf("t2_g%0d_c1", k), e, 3'(k % 8), 1'b1, 1'b0);
         cyc();
         chk_out($sformatf("t2_g%0d_c2", k), e, 3'(k % 8), 1'b1, 1'b0);
         done = 1'b1;
         cyc();
         done = 1'b0;
         chk_out($sformatf("t2_g%0d_idle", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
      end
      chk_ptr("t2_end", 3'd2);

      // Steer ptr to 6, then requesters 6 and 0 contend across the wrap
      req = 8'h20;
      cyc();
      chk_out("t3_g5", 8'h20, 3'd5, 1'b1, 1'b0);
      req = 8'h00;
      cyc();
      chk_ptr("t3_ptr6", 3'd6);
      req = 8'h41;
      cyc();
      chk_out("t3_g6", 8'h40, 3'd6, 1'b1, 1'b0);
      done = 1'b1;
      cyc();
      done = 1'b0;
      chk_out("t3_rel6", 8'h00, 3'd6, 1'b0, 1'b0);
      chk_ptr("t3_rel6", 3'd7);
      cyc();
      chk_out("t3_g0", 8'h01, 3'd0, 1'b1, 1'b0);
      req = 8'h00;
      cyc();
      chk_out("t3_rel0", 8'h00, 3'd0, 1'b0, 1'b0);

      // Hold limit with MAX_HOLD=4
      req = 8'h10;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk_out($sformatf("t4_hold%0d", k), 8'h10, 3'd4, 1'b1, 1'b0);
      end
      cyc();
      chk_out("t4_timeout", 8'h00, 3'd4, 1'b0, 1'b1);
      cyc();
      chk_out("t4_regrant", 8'h10, 3'd4, 1'b1, 1'b0);

      // done and req drop together on the limit cycle: normal release
      cyc();
      cyc();
      cyc();
      chk_out("t5_cyc4", 8'h10, 3'd4, 1'b1, 1'b0);
      done = 1'b1;
      req  = 8'h00;
      cyc();
      done = 1'b0;
      chk_out("t5_coincide", 8'h00, 3'd4, 1'b0, 1'b0);
      chk_ptr("t5_coincide", 3'd5);

      // Owner drops its request while another bit rises
      req = 8'h08;
      cyc();
      chk_out("t5_g3", 8'h08, 3'd3, 1'b1, 1'b0);
      req = 8'h02;
      cyc();
      chk_out("t5_drop", 8'h00, 3'd3, 1'b0, 1'b0);
      cyc();
      chk_out("t5_g1", 8'h02, 3'd1, 1'b1, 1'b0);
      req = 8'h06;
      cyc();
      chk_out("t5_other_bits", 8'h02, 3'd1, 1'b1, 1'b0);
      req = 8'h00;
      cyc();
      chk_out("t5_rel1", 8'h00, 3'd1, 1'b0, 1'b0);

      // Reset in the middle of a grant
      req = 8'h20;
      cyc();
      chk_out("t6_g5", 8'h20, 3'd5, 1'b1, 1'b0);
      rst = 1'b1;
      req = 8'h21;
      cyc();
      chk_out("t6_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      chk_ptr("t6_rst", 3'd0);
      rst = 1'b0;
      cyc();
      chk_out("t6_g0", 8'h01, 3'd0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
